toggle_stim_gen: RTL and testbench

//  Synchronous stimulus source for the switch-level inverter stage. Drives sw_in, the

---
 rtl/toggle_stim_gen.sv | 103 ++++++++++
 tb/tb_toggle_stim_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/toggle_stim_gen.sv
// Programmable square-wave stimulus source for the switch-level inverter input.
// Produces a fixed number of sw_in transitions spaced half_period clocks apart, with busy/done status.
module toggle_stim_gen #(
  parameter int   CNT_W    = 16,
  parameter int   NUM_W    = 8,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] half_period,
  input  logic [NUM_W-1:0] num_toggles,
  output logic             sw_in,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] toggles_done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_hp;
  logic [NUM_W-1:0] r_nt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sw;
  logic             r_busy;
  logic             r_done;
  logic [NUM_W-1:0] r_tdone;

  logic [CNT_W-1:0] w_hp_eff;
  logic [NUM_W-1:0] w_tdone_nxt;
  logic             w_accept;

  // A zero half-period would never let the counter expire; treat it as one cycle.
  assign w_hp_eff    = (half_period == '0) ? CNT_W'(1) : half_period;
  assign w_tdone_nxt = r_tdone + NUM_W'(1);
  assign w_accept    = start && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_hp    <= '0;
      r_nt    <= '0;
      r_cnt   <= '0;
      r_sw    <= IDLE_LVL;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tdone <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_hp    <= w_hp_eff;
            r_nt    <= num_toggles;
            r_sw    <= IDLE_LVL;
            r_tdone <= '0;
            if (num_toggles == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_cnt   <= w_hp_eff - CNT_W'(1);
            end
          end
        end
        S_RUN: begin
          // Abort outranks a toggle due on the same edge, so the final toggle never lands.
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_sw    <= IDLE_LVL;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_sw    <= ~r_sw;
            r_tdone <= w_tdone_nxt;
            r_cnt   <= r_hp - CNT_W'(1);
            if (w_tdone_nxt == r_nt) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sw_in        = r_sw;
  assign busy         = r_busy;
  assign done         = r_done;
  assign toggles_done = r_tdone;

endmodule

// File: tb/tb_toggle_stim_gen.sv
// Bench for toggle_stim_gen: run table, directed corner sequences and random stimulus,
// all compared each cycle against a run-level arithmetic model (toggles = elapsed / hp).
module tb_toggle_stim_gen;
  localparam int   CNT_W = 16;
  localparam int   NUM_W = 8;
  localparam logic IDLE  = 1'b0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] half_period;
  logic [NUM_W-1:0] num_toggles;
  logic             sw_in;
  logic             busy;
  logic             done;
  logic [NUM_W-1:0] toggles_done;

  toggle_stim_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W), .IDLE_LVL(IDLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .half_period(half_period), .num_toggles(num_toggles),
    .sw_in(sw_in), .busy(busy), .done(done), .toggles_done(toggles_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Run-level model: a run accepted at edge t0 has produced min((n-t0)/hp, nt) toggles by edge n.
  int   n = 0;
  bit   m_run = 0;
  int   m_t0, m_hp, m_nt;
  int   m_td = 0;
  logic m_sw = IDLE;
  logic m_busy = 0;
  logic m_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 60)
        $display("FAIL %s @edge %0d: got %0d expected %0d", name, n, act, exp);
    end
  endtask

  task automatic model_edge();
    int k;
    m_done = 1'b0;
    if (!rst_n) begin
      m_run = 0; m_busy = 0; m_sw = IDLE; m_td = 0;
    end else if (m_run) begin
      if (abort) begin
        m_run = 0; m_busy = 0; m_sw = IDLE;
      end else begin
        k = (n - m_t0) / m_hp;
        m_td = k;
        m_sw = IDLE ^ k[0];
        if (k == m_nt) begin
          m_run = 0; m_busy = 0; m_done = 1;
        end
      end
    end else if (start && !abort) begin
      m_t0 = n;
      m_hp = (half_period == '0) ? 1 : int'(half_period);
      m_nt = int'(num_toggles);
      m_td = 0;
      m_sw = IDLE;
      if (m_nt == 0) m_done = 1;
      else begin m_run = 1; m_busy = 1; end
    end
  endtask

  task automatic compare_all();
    check("sw_in", 32'(sw_in), 32'(m_sw));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("toggles_done", 32'(toggles_done), 32'(m_td));
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    model_edge();
    #1;
    compare_all();
  endtask

  typedef struct {
    int   hp;
    int   nt;
    int   abort_at;   // edge offset from acceptance; 0 means no abort
    logic exp_sw;
    int   exp_td;
    bit   exp_done;
    bit   exp_busy;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input int idx);
    bit seen_done = 0;
    bit seen_busy = 0;
    int limit;
    half_period = CNT_W'(v.hp);
    num_toggles = NUM_W'(v.nt);
    start = 1'b1;
    tick();
    start = 1'b0;
    seen_done |= done; seen_busy |= busy;
    limit = ((v.hp == 0) ? 1 : v.hp) * v.nt + 4;
    for (int r = 1; r <= limit && busy; r++) begin
      abort = (r == v.abort_at);
      tick();
      abort = 1'b0;
      seen_done |= done; seen_busy |= busy;
    end
    check($sformatf("vec%0d_terminated", idx), 32'(busy), 32'd0);
    tick();
    check($sformatf("vec%0d_final_sw", idx), 32'(sw_in), 32'(v.exp_sw));
    check($sformatf("vec%0d_final_td", idx), 32'(toggles_done), 32'(v.exp_td));
    check($sformatf("vec%0d_done_seen", idx), 32'(seen_done), 32'(v.exp_done));
    check($sformatf("vec%0d_busy_seen", idx), 32'(seen_busy), 32'(v.exp_busy));
    check($sformatf("vec%0d_done_cleared", idx), 32'(done), 32'd0);
  endtask

  initial begin
    vecs[0] = '{hp:10, nt:10,  abort_at:0,  exp_sw:IDLE,  exp_td:10,  exp_done:1, exp_busy:1};
    vecs[1] = '{hp:7,  nt:0,   abort_at:0,  exp_sw:IDLE,  exp_td:0,   exp_done:1, exp_busy:0};
    vecs[2] = '{hp:0,  nt:3,   abort_at:0,  exp_sw:~IDLE, exp_td:3,   exp_done:1, exp_busy:1};
    vecs[3] = '{hp:4,  nt:8,   abort_at:13, exp_sw:IDLE,  exp_td:3,   exp_done:0, exp_busy:1};
    vecs[4] = '{hp:3,  nt:4,   abort_at:12, exp_sw:IDLE,  exp_td:3,   exp_done:0, exp_busy:1};
    vecs[5] = '{hp:1,  nt:255, abort_at:0,  exp_sw:~IDLE, exp_td:255, exp_done:1, exp_busy:1};
    vecs[6] = '{hp:2,  nt:5,   abort_at:0,  exp_sw:~IDLE, exp_td:5,   exp_done:1, exp_busy:1};

    // Reset held with start asserted: nothing may happen.
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; half_period = 16'd5; num_toggles = 8'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_sw", 32'(sw_in), 32'(IDLE));
      check("rst_busy", 32'(busy), 32'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // start re-pulsed mid-run with new values must be ignored.
    half_period = 16'd10; num_toggles = 8'd10; start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 1; r <= 105 && busy; r++) begin
      if (r == 5) begin start = 1'b1; half_period = 16'd2; num_toggles = 8'd3; end
      tick();
      start = 1'b0;
    end
    check("restart_ignored_td", 32'(toggles_done), 32'd10);
    check("restart_ignored_busy", 32'(busy), 32'd0);
    tick();

    // start together with abort in idle: abort wins.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle_busy", 32'(busy), 32'd0);
    check("start_abort_idle_done", 32'(done), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Asynchronous reset dropped between edges mid-run.
    half_period = 16'd10; num_toggles = 8'd10; start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 1; r <= 7; r++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sw", 32'(sw_in), 32'(IDLE));
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_td", 32'(toggles_done), 32'd0);
    tick();
    rst_n = 1'b1;
    run_vec(vecs[6], 7);

    // Random free-running stimulus.
    for (int i = 0; i < 1500; i++) begin
      start       = ($urandom_range(0, 5) == 0);
      abort       = ($urandom_range(0, 24) == 0);
      half_period = CNT_W'($urandom_range(0, 5));
      num_toggles = NUM_W'($urandom_range(0, 12));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
